// File: rtl/shift_register_universal.sv
// Universal shift register (hold / shift left / shift right / load) with a shift counter and word-complete pulse.
// Latency 1 clk on qualified edges (clockEdge=1); no backpressure, the caller paces updates through clockEdge.
module shift_register_universal #(
  parameter int               width      = 8,
  parameter logic [width-1:0] resetValue = '0,
  parameter int               cntWidth   = $clog2(width + 1)
) (
  input  logic                clk,
  input  logic                resetN,
  input  logic                clockEdge,
  input  logic [1:0]          mode,
  input  logic                serialIn,
  input  logic [width-1:0]    parallelIn,
  output logic [width-1:0]    parallelOut,
  output logic                serialOutMsb,
  output logic                serialOutLsb,
  output logic [cntWidth-1:0] shiftCount,
  output logic                wordDone
);

  localparam logic [1:0] MODE_HOLD  = 2'b00;
  localparam logic [1:0] MODE_LEFT  = 2'b01;
  localparam logic [1:0] MODE_RIGHT = 2'b10;
  localparam logic [1:0] MODE_LOAD  = 2'b11;

  localparam logic [cntWidth-1:0] CNT_LAST = cntWidth'(width - 1);

  logic               shift_evt;
  logic               word_end;
  logic [width-1:0]   data_nxt;

  assign shift_evt = clockEdge && ((mode == MODE_LEFT) || (mode == MODE_RIGHT));
  assign word_end  = shift_evt && (shiftCount == CNT_LAST);

  always_comb begin
    data_nxt = parallelOut;
    case (mode)
      MODE_LEFT:  data_nxt = {parallelOut[width-2:0], serialIn};
      MODE_RIGHT: data_nxt = {serialIn, parallelOut[width-1:1]};
      MODE_LOAD:  data_nxt = parallelIn;
      default:    data_nxt = parallelOut;
    endcase
  end

  // wordDone clears on every clk, so it is never wider than one cycle even while clockEdge is low.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      parallelOut <= resetValue;
      shiftCount  <= '0;
      wordDone    <= 1'b0;
    end else begin
      wordDone <= word_end;
      if (clockEdge) begin
        parallelOut <= data_nxt;
        if (mode == MODE_LOAD || word_end) begin
          shiftCount <= '0;
        end else if (shift_evt) begin
          shiftCount <= shiftCount + cntWidth'(1);
        end
      end
    end
  end

  assign serialOutMsb = parallelOut[width-1];
  assign serialOutLsb = parallelOut[0];

endmodule

// File: tb/tb_shift_register_universal.sv
// Directed bench for shift_register_universal at width=8, resetValue=8'hA5.
module tb_shift_register_universal;

  logic       clk = 1'b0;
  logic       resetN;
  logic       clockEdge;
  logic [1:0] mode;
  logic       serialIn;
  logic [7:0] parallelIn;
  logic [7:0] parallelOut;
  logic       serialOutMsb;
  logic       serialOutLsb;
  logic [3:0] shiftCount;
  logic       wordDone;

  int n_checks = 0;
  int n_fail   = 0;

  // Hand-computed left-shift walk from 8'h3C.
  logic       t2_si  [8] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
  logic       t2_msb [8] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
  logic [7:0] t2_po  [8] = '{8'h79, 8'hF2, 8'hE5, 8'hCB, 8'h96, 8'h2C, 8'h59, 8'hB2};

  shift_register_universal #(
    .width      (8),
    .resetValue (8'hA5)
  ) dut (
    .clk          (clk),
    .resetN       (resetN),
    .clockEdge    (clockEdge),
    .mode         (mode),
    .serialIn     (serialIn),
    .parallelIn   (parallelIn),
    .parallelOut  (parallelOut),
    .serialOutMsb (serialOutMsb),
    .serialOutLsb (serialOutLsb),
    .shiftCount   (shiftCount),
    .wordDone     (wordDone)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic step(input logic ce, input logic [1:0] m, input logic si, input logic [7:0] pi);
    clockEdge  = ce;
    mode       = m;
    serialIn   = si;
    parallelIn = pi;
    tick();
  endtask

  initial begin
    int         pulses;
    logic [7:0] exp_po;

    resetN     = 1'b0;
    clockEdge  = 1'b0;
    mode       = 2'b00;
    serialIn   = 1'b0;
    parallelIn = 8'h00;
    tick();
    tick();
    check_eq("rst_po",   32'(parallelOut), 32'h A5);
    check_eq("rst_cnt",  32'(shiftCount),  0);
    check_eq("rst_done", 32'(wordDone),    0);
    check_eq("rst_msb",  32'(serialOutMsb), 1);
    check_eq("rst_lsb",  32'(serialOutLsb), 1);
    resetN = 1'b1;

    // Asynchronous reset between clk edges.
    step(1'b1, 2'b11, 1'b0, 8'h5A);
    check_eq("ld_po", 32'(parallelOut), 32'h5A);
    step(1'b1, 2'b01, 1'b1, 8'h00);
    check_eq("sh1_po",  32'(parallelOut), 32'hB5);
    check_eq("sh1_cnt", 32'(shiftCount),  1);
    #3 resetN = 1'b0;
    #1;
    check_eq("arst_po",   32'(parallelOut), 32'hA5);
    check_eq("arst_cnt",  32'(shiftCount),  0);
    check_eq("arst_done", 32'(wordDone),    0);
    #2 resetN = 1'b1;

    // Load 3C then eight left shifts.
    step(1'b1, 2'b11, 1'b0, 8'h3C);
    check_eq("t2_ld_po",  32'(parallelOut), 32'h3C);
    check_eq("t2_ld_cnt", 32'(shiftCount),  0);
    for (int i = 0; i < 8; i++) begin
      check_eq("t2_msb_pre", 32'(serialOutMsb), 32'(t2_msb[i]));
      step(1'b1, 2'b01, t2_si[i], 8'h00);
      check_eq("t2_po",   32'(parallelOut),  32'(t2_po[i]));
      check_eq("t2_lsb",  32'(serialOutLsb), 32'(t2_si[i]));
      check_eq("t2_cnt",  32'(shiftCount),   (i == 7) ? 0 : i + 1);
      check_eq("t2_done", 32'(wordDone),     32'(i == 7));
    end
    step(1'b0, 2'b01, 1'b1, 8'h00);
    check_eq("t2_done_clr", 32'(wordDone),    0);
    check_eq("t2_po_hold",  32'(parallelOut), 32'hB2);

    // Right shifts qualified every third clk.
    step(1'b1, 2'b11, 1'b0, 8'h81);
    check_eq("t3_ld_po", 32'(parallelOut), 32'h81);
    pulses = 0;
    for (int k = 1; k <= 8; k++) begin
      step(1'b1, 2'b10, 1'b0, 8'h00);
      exp_po = 8'h81 >> k;
      pulses += int'(wordDone);
      check_eq("t3_po",   32'(parallelOut), 32'(exp_po));
      check_eq("t3_done", 32'(wordDone),    32'(k == 8));
      for (int j = 0; j < 2; j++) begin
        step(1'b0, 2'b10, 1'b1, 8'h55);
        pulses += int'(wordDone);
        check_eq("t3_gap_po",   32'(parallelOut), 32'(exp_po));
        check_eq("t3_gap_done", 32'(wordDone),    0);
        check_eq("t3_gap_cnt",  32'(shiftCount),  (k == 8) ? 0 : k);
      end
    end
    check_eq("t3_pulses", 32'(pulses), 1);

    // Load in the middle of a word restarts the count.
    step(1'b1, 2'b11, 1'b0, 8'h00);
    exp_po = 8'h00;
    for (int i = 1; i <= 5; i++) begin
      step(1'b1, 2'b01, 1'b1, 8'h00);
      exp_po = {exp_po[6:0], 1'b1};
      check_eq("t4_pre_po", 32'(parallelOut), 32'(exp_po));
    end
    check_eq("t4_pre_cnt", 32'(shiftCount), 5);
    step(1'b1, 2'b11, 1'b0, 8'hFF);
    check_eq("t4_ld_po",   32'(parallelOut), 32'hFF);
    check_eq("t4_ld_cnt",  32'(shiftCount),  0);
    check_eq("t4_ld_done", 32'(wordDone),    0);
    exp_po = 8'hFF;
    pulses = 0;
    for (int i = 1; i <= 8; i++) begin
      step(1'b1, 2'b01, 1'b0, 8'h00);
      exp_po = {exp_po[6:0], 1'b0};
      pulses += int'(wordDone);
      check_eq("t4_po",   32'(parallelOut), 32'(exp_po));
      check_eq("t4_done", 32'(wordDone),    32'(i == 8));
    end
    check_eq("t4_pulses", 32'(pulses), 1);

    // Mixed direction with holds: all shifts count toward the word.
    step(1'b1, 2'b11, 1'b0, 8'h0F);
    for (int i = 1; i <= 4; i++) begin
      step(1'b1, 2'b01, 1'b1, 8'h00);
      check_eq("t5_l_cnt",  32'(shiftCount), i);
      check_eq("t5_l_done", 32'(wordDone),   0);
    end
    check_eq("t5_l_po", 32'(parallelOut), 32'hFF);
    for (int i = 0; i < 2; i++) begin
      step(1'b1, 2'b00, 1'b0, 8'h00);
      check_eq("t5_h_po",  32'(parallelOut), 32'hFF);
      check_eq("t5_h_cnt", 32'(shiftCount),  4);
    end
    for (int i = 1; i <= 4; i++) begin
      step(1'b1, 2'b10, 1'b0, 8'h00);
      check_eq("t5_r_done", 32'(wordDone),   32'(i == 4));
      check_eq("t5_r_cnt",  32'(shiftCount), (i == 4) ? 0 : 4 + i);
    end
    check_eq("t5_r_po", 32'(parallelOut), 32'h0F);
    step(1'b1, 2'b10, 1'b0, 8'h00);
    step(1'b1, 2'b10, 1'b0, 8'h00);
    check_eq("t5_end_po",  32'(parallelOut), 32'h03);
    check_eq("t5_end_cnt", 32'(shiftCount),  2);

    // Continuous shifting: a pulse every eight shifts with no dead cycle.
    step(1'b1, 2'b11, 1'b0, 8'h00);
    exp_po = 8'h00;
    pulses = 0;
    for (int i = 1; i <= 16; i++) begin
      step(1'b1, 2'b01, 1'(i), 8'h00);
      exp_po = {exp_po[6:0], 1'(i)};
      pulses += int'(wordDone);
      check_eq("t6_po",   32'(parallelOut), 32'(exp_po));
      check_eq("t6_done", 32'(wordDone),    32'(i == 8 || i == 16));
    end
    check_eq("t6_pulses", 32'(pulses), 2);
    for (int i = 1; i <= 3; i++) begin
      step(1'b1, 2'b01, 1'b1, 8'h00);
    end
    check_eq("t6_pre_rst_cnt", 32'(shiftCount), 3);
    #3 resetN = 1'b0;
    #1;
    check_eq("t6_rst_cnt", 32'(shiftCount),  0);
    check_eq("t6_rst_po",  32'(parallelOut), 32'hA5);
    clockEdge = 1'b1;
    mode      = 2'b11;
    parallelIn = 8'h00;
    tick();
    check_eq("t6_rst_hold_po", 32'(parallelOut), 32'hA5);
    #2 resetN = 1'b1;
    pulses = 0;
    for (int i = 1; i <= 8; i++) begin
      step(1'b1, 2'b01, 1'b0, 8'h00);
      pulses += int'(wordDone);
      check_eq("t6_fresh_done", 32'(wordDone),   32'(i == 8));
      check_eq("t6_fresh_cnt",  32'(shiftCount), (i == 8) ? 0 : i);
    end
    check_eq("t6_fresh_pulses", 32'(pulses), 1);
    check_eq("t6_fresh_po", 32'(parallelOut), 32'h00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/shift_register_universal.md
Name: shift_register_universal

Overview:
- Parametrised universal shift register: the successor to the single-stage width-parameterised DFF.
- Same clk plus clockEdge qualified-update scheme.
- Adds four modes (hold, shift left, shift right, parallel load), a shift counter, and a word-complete pulse.
- Serves as the serial/parallel conversion element for the peripheral datapath (SPI-style front end).
- Reset is asynchronous and active-low.

Parameters:
- width, 8: register width in bits (>= 2).
- resetValue, 0: value loaded into parallelOut on reset (width bits).
- cntWidth, $clog2(width+1): shiftCount width. Derived; must not be overridden.

Ports:
- clk  input  1  global FPGA clock; all state changes on posedge.
- resetN  input  1  asynchronous active-low reset.
- clockEdge  input  1  device clock edge qualifier; state advances only on posedge clk with clockEdge=1.
- mode  input  2  00 hold, 01 shift left, 10 shift right, 11 parallel load.
- serialIn  input  1  bit shifted in (LSB on left shift, MSB on right shift).
- parallelIn  input  width  word loaded in mode 11.
- parallelOut  output  width  register contents.
- serialOutMsb  output  1  parallelOut[width-1]; combinational from the register.
- serialOutLsb  output  1  parallelOut[0]; combinational from the register.
- shiftCount  output  cntWidth  shifts since last load, reset, or word completion.
- wordDone  output  1  one-clk pulse after the width-th shift.

Behaviour:
- Reset, asynchronous on resetN=0 regardless of clk: parallelOut=resetValue, shiftCount=0, wordDone=0. Outputs stay there while resetN=0.
- Reset mid-word: partial count is discarded. First qualified edge after release is treated normally.
- Update event: posedge clk with resetN=1 and clockEdge=1. Register latency 1 clk; serialOut* follow parallelOut with no extra delay.
- mode 00, hold: parallelOut and shiftCount unchanged.
- mode 01, shift left: parallelOut <= {parallelOut[width-2:0], serialIn}.
- mode 10, shift right: parallelOut <= {serialIn, parallelOut[width-1:1]}.
- mode 11, load: parallelOut <= parallelIn; shiftCount <= 0; wordDone not asserted.
- Counter:
  - Each shift event (01 or 10) increments shiftCount.
  - When the increment would reach width, shiftCount <= 0 and wordDone <= 1 on that same edge. wordDone is therefore high for the clk cycle after the width-th shift.
  - wordDone is cleared on the next posedge clk unconditionally, independent of clockEdge. It is never high for more than one clk.
  - Direction changes mid-word do not clear the count: mixed left/right shifts all count.
  - Back-to-back words with continuous shifting give a wordDone pulse every width qualified shifts with no dead cycle.
- clockEdge=0: no change to parallelOut or shiftCount. mode, serialIn and parallelIn are ignored.
- Illegal values: none; all four mode codes are defined.
- No combinational path from inputs to outputs.

Test Plan (width=8, resetValue=8'hA5 unless noted):
- Reset: assert resetN=0 asynchronously between clk edges -> parallelOut=8'hA5, shiftCount=0, wordDone=0 immediately, before the next edge.
- Load + left shift: load 8'h3C, then 8 qualified left shifts with serialIn pattern 1,0,1,1,0,0,1,0.
  - serialOutMsb sequence before each shift: 0,0,1,1,1,1,0,0.
  - Final parallelOut=8'hB2; shiftCount 1..7 then 0.
  - wordDone high exactly one clk after the 8th shift.
- Right shift with gaps: load 8'h81, right-shift serialIn=0 with clockEdge=1 every third clk for 8 shifts.
  - parallelOut unchanged on unqualified clks.
  - Final parallelOut=8'h00; one wordDone pulse, 1 clk wide.
- Load mid-word: 5 left shifts, then load 8'hFF -> shiftCount=0, no wordDone. 8 further shifts produce exactly one wordDone.
- Mixed direction + hold: 4 left, 2 hold, 4 right shifts -> wordDone after the 8th shift (the 4th right shift); shiftCount=2 at end.
- Continuous: 16 consecutive qualified left shifts -> wordDone pulses after shifts 8 and 16 only. Then assert resetN=0 after 3 more shifts -> shiftCount=0, and a fresh 8-shift word is required before the next wordDone.
